// File: rtl/fetch_inst_buffer_pkg.sv
// Shared types for the instruction buffer: PC, instruction word and queue entry.
package riscv_pkg;
  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  typedef logic [XLEN-1:0]   pc_t;
  typedef logic [INST_W-1:0] inst_t;

  typedef struct packed {
    pc_t   pc;
    inst_t word;
  } ibuf_entry_t;
endpackage

// File: rtl/fib_fifo2.sv
// Circular instruction queue: up to two writes and one read per cycle, flush, occupancy.
module fib_fifo2
  import riscv_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [1:0]               wr_n,
  input  ibuf_entry_t              wr_d0,
  input  ibuf_entry_t              wr_d1,
  input  logic                     rd_en,
  output ibuf_entry_t              head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ibuf_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;

  // Storage: second write lands one slot later; pointer width makes it wrap naturally.
  always_ff @(posedge clk) begin
    if (!flush && wr_n != 2'd0) mem[wr_ptr] <= wr_d0;
    if (!flush && wr_n == 2'd2) mem[wr_ptr + AW'(1)] <= wr_d1;
  end

  // Pointers and count; the writer never overfills and the reader never reads empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_n);
      rd_ptr <= rd_ptr + AW'(rd_en);
      cnt    <= cnt + CW'(wr_n) - CW'(rd_en);
    end
  end

  // Empty queue presents zeros so the head outputs are deterministic.
  assign head  = (cnt != '0) ? mem[rd_ptr] : '0;
  assign count = cnt;
endmodule

// File: rtl/fetch_inst_buffer.sv
// Instruction buffer: splits 64-bit fetch beats into PC-tagged instructions, issues in order,
// and drops stale beats after an executer redirect.
module fetch_inst_buffer
  import riscv_pkg::*;
#(
  parameter int  DEPTH    = 8,
  parameter pc_t RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_valid,
  output logic                   fetch_ready,
  input  logic [XLEN-1:0]        fetch_addr,
  input  logic [63:0]            fetch_data,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [XLEN-1:0]        inst_pc,
  output logic [INST_W-1:0]      inst_word,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int OW = $clog2(DEPTH) + 1;

  pc_t         exp_pc;
  logic        accept, match;
  logic [1:0]  wr_n;
  logic        rd_en;
  ibuf_entry_t wr_d0, wr_d1, head;
  logic        unused_bits;

  // Low address bits carry no information: beats are 8-byte aligned, PCs 4-byte aligned.
  assign unused_bits = ^{fetch_addr[2:0], redirect_pc[1:0]};

  assign fetch_ready = occupancy <= OW'(DEPTH - 2);
  assign inst_valid  = occupancy != '0;

  // A redirect wins the cycle: same-cycle beat and dequeue are discarded.
  assign accept = fetch_valid && fetch_ready && !redirect_valid;
  assign match  = fetch_addr[XLEN-1:3] == exp_pc[XLEN-1:3];
  assign rd_en  = inst_valid && inst_ready && !redirect_valid;

  // Split logic: an odd-word exp_pc takes only the upper half, which realigns the stream.
  always_comb begin
    wr_n  = 2'd0;
    wr_d0 = '{pc: exp_pc, word: exp_pc[2] ? fetch_data[63:32] : fetch_data[31:0]};
    wr_d1 = '{pc: exp_pc + pc_t'(4), word: fetch_data[63:32]};
    if (accept && match) wr_n = exp_pc[2] ? 2'd1 : 2'd2;
  end

  // Expected fetch PC tracks the next instruction to enqueue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              exp_pc <= RESET_PC;
    else if (redirect_valid) exp_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    else if (accept && match) exp_pc <= exp_pc + (exp_pc[2] ? pc_t'(4) : pc_t'(8));
  end

  fib_fifo2 #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .wr_n  (wr_n),
    .wr_d0 (wr_d0),
    .wr_d1 (wr_d1),
    .rd_en (rd_en),
    .head  (head),
    .count (occupancy)
  );

  assign inst_pc   = head.pc;
  assign inst_word = head.word;
endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Directed bench: table of single-cycle vectors plus hand sequences for fill, wrap and reset.
module tb_fetch_inst_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid, fetch_ready;
  logic [63:0] fetch_addr, fetch_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [63:0] inst_pc;
  logic [31:0] inst_word;
  logic [3:0]  occupancy;

  int checks = 0;
  int errors = 0;

  fetch_inst_buffer #(.DEPTH(8), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst_word(inst_word),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [63:0] addr;
    logic [63:0] data;
    logic        rv;
    logic [63:0] rpc;
    logic        ir;
    logic        ev;
    logic [3:0]  eocc;
    logic        efr;
    logic [63:0] epc;
    logic [31:0] ew;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] w(input logic [63:0] p);
    return {8'hA5, p[23:0]};
  endfunction

  function automatic logic [63:0] beat(input logic [63:0] a);
    return {w(a + 64'd4), w(a)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step(input logic fv, input logic [63:0] a, input logic [63:0] d,
                      input logic rv, input logic [63:0] rpc, input logic ir);
    fetch_valid = fv; fetch_addr = a; fetch_data = d;
    redirect_valid = rv; redirect_pc = rpc; inst_ready = ir;
    @(posedge clk); #1;
    fetch_valid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic chk_all(input string nm, input logic ev, input logic [3:0] eocc,
                         input logic efr, input logic [63:0] epc, input logic [31:0] ew);
    chk({nm, "_valid"}, 64'(inst_valid), 64'(ev));
    chk({nm, "_occ"},   64'(occupancy),  64'(eocc));
    chk({nm, "_fready"}, 64'(fetch_ready), 64'(efr));
    chk({nm, "_pc"},    inst_pc,         epc);
    chk({nm, "_word"},  64'(inst_word),  64'(ew));
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_valid = 1'b0; fetch_addr = '0; fetch_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    // fv addr data rv rpc ir | valid occ fready pc word
    vt.push_back('{1, 64'h0,   64'h00500093_00300113, 0, 64'h0, 0, 1, 2, 1, 64'h0, 32'h00300113});
    vt.push_back('{0, 64'h0,   64'h0, 0, 64'h0, 1, 1, 1, 1, 64'h4, 32'h00500093});
    vt.push_back('{0, 64'h0,   64'h0, 0, 64'h0, 1, 0, 0, 1, 64'h0, 32'h0});
    vt.push_back('{0, 64'h0,   64'h0, 1, 64'h104, 0, 0, 0, 1, 64'h0, 32'h0});
    vt.push_back('{1, 64'h100, 64'hAAAA0001_BBBB0001, 0, 64'h0, 0, 1, 1, 1, 64'h104, 32'hAAAA0001});
    vt.push_back('{1, 64'h108, 64'hCCCC0002_DDDD0002, 0, 64'h0, 1, 1, 2, 1, 64'h108, 32'hDDDD0002});
    vt.push_back('{0, 64'h0,   64'h0, 0, 64'h0, 1, 1, 1, 1, 64'h10C, 32'hCCCC0002});
    vt.push_back('{0, 64'h0,   64'h0, 0, 64'h0, 1, 0, 0, 1, 64'h0, 32'h0});
    vt.push_back('{0, 64'h0,   64'h0, 1, 64'h200, 0, 0, 0, 1, 64'h0, 32'h0});
    vt.push_back('{1, 64'h40,  64'h99999999_88888888, 0, 64'h0, 0, 0, 0, 1, 64'h0, 32'h0});
    vt.push_back('{1, 64'h200, 64'h11111111_22222222, 0, 64'h0, 0, 1, 2, 1, 64'h200, 32'h22222222});
    vt.push_back('{1, 64'h300, 64'h33333333_44444444, 1, 64'h300, 1, 0, 0, 1, 64'h0, 32'h0});
    vt.push_back('{1, 64'h300, 64'h33333333_44444444, 0, 64'h0, 0, 1, 2, 1, 64'h300, 32'h44444444});
    vt.push_back('{0, 64'h0,   64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 1, 64'h0, 32'h0});
    vt.push_back('{1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h55555555_66666666, 0, 64'h0, 0,
                   1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h55555555});
    vt.push_back('{1, 64'h0,   64'h77777777_88888888, 0, 64'h0, 1, 1, 2, 1, 64'h0, 32'h88888888});
    vt.push_back('{0, 64'h0,   64'h0, 0, 64'h0, 1, 1, 1, 1, 64'h4, 32'h77777777});
    vt.push_back('{0, 64'h0,   64'h0, 0, 64'h0, 1, 0, 0, 1, 64'h0, 32'h0});

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk_all("reset", 0, 0, 1, 64'h0, 32'h0);

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].fv, vt[i].addr, vt[i].data, vt[i].rv, vt[i].rpc, vt[i].ir);
      chk_all($sformatf("v%0d", i), vt[i].ev, vt[i].eocc, vt[i].efr, vt[i].epc, vt[i].ew);
    end

    // Fill to DEPTH with no consumer, then drain and check order.
    step(0, 0, 0, 1, 64'h1000, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 64'h1000 + 64'(8 * k), beat(64'h1000 + 64'(8 * k)), 0, 0, 0);
      chk($sformatf("fill%0d_occ", k), 64'(occupancy), 64'(2 * (k + 1)));
      chk($sformatf("fill%0d_fready", k), 64'(fetch_ready), (k < 3) ? 64'd1 : 64'd0);
    end
    step(1, 64'h1020, beat(64'h1020), 0, 0, 0);
    chk("full_hold_occ", 64'(occupancy), 64'd8);
    step(0, 0, 0, 0, 0, 1);
    chk_all("occ7", 1, 7, 0, 64'h1004, w(64'h1004));
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("drain%0d_pc", i), inst_pc, 64'h1000 + 64'(4 * i));
      chk($sformatf("drain%0d_word", i), 64'(inst_word), 64'(w(64'h1000 + 64'(4 * i))));
      step(0, 0, 0, 0, 0, 1);
    end
    chk("drained_valid", 64'(inst_valid), 64'd0);

    // Wrap: occupancy 6 with write slot 7, then enqueue two and dequeue one together.
    step(0, 0, 0, 1, 64'h2007, 0);
    step(1, 64'h2000, beat(64'h2000), 0, 0, 0);
    chk_all("realign", 1, 1, 1, 64'h2004, w(64'h2004));
    for (int k = 1; k < 4; k++) step(1, 64'h2000 + 64'(8 * k), beat(64'h2000 + 64'(8 * k)), 0, 0, 0);
    chk("wrap_occ7_fready", 64'(fetch_ready), 64'd0);
    step(0, 0, 0, 0, 0, 1);
    chk_all("wrap_occ6", 1, 6, 1, 64'h2008, w(64'h2008));
    step(1, 64'h2020, beat(64'h2020), 0, 0, 1);
    chk("wrap_occ", 64'(occupancy), 64'd7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("wrap%0d_pc", i), inst_pc, 64'h200C + 64'(4 * i));
      chk($sformatf("wrap%0d_word", i), 64'(inst_word), 64'(w(64'h200C + 64'(4 * i))));
      step(0, 0, 0, 0, 0, 1);
    end
    chk("wrap_end_occ", 64'(occupancy), 64'd0);

    // Reset with five entries held.
    step(0, 0, 0, 1, 64'h3004, 0);
    step(1, 64'h3000, beat(64'h3000), 0, 0, 0);
    step(1, 64'h3008, beat(64'h3008), 0, 0, 0);
    step(1, 64'h3010, beat(64'h3010), 0, 0, 0);
    chk("pre_rst_occ", 64'(occupancy), 64'd5);
    #1 rst_n = 1'b0;
    #1 chk_all("mid_rst", 0, 0, 1, 64'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 64'h3018, beat(64'h3018), 0, 0, 0);
    chk("post_rst_stale_occ", 64'(occupancy), 64'd0);
    step(1, 64'h0, beat(64'h0), 0, 0, 0);
    chk_all("post_rst", 1, 2, 1, 64'h0, w(64'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
